sap2_computer: RTL and testbench
================================

SAP2_COMPUTER -- requirements
Module: sap2_computer

Interface
REQ-001 The block SHALL provide these parameters: DATA_WIDTH, default 8, datapath width; ADDR_WIDTH, default 4, address and PC width.
REQ-002 The block SHALL provide these ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset.
- out_val  out  DATA_WIDTH  contents of the OUT register.
- flag_zero_o  out  1  Z flag.
- flag_carry_o  out  1  C flag.
- flag_negative_o  out  1  N flag.

Function
REQ-003 Memory SHALL be a 16-byte RAM holding both code and data; it is not initialised by reset and is loaded externally.
REQ-004 An instruction SHALL be one byte: bits [7:4] are the opcode and bits [3:0] are the operand (an address or a 4-bit immediate).
REQ-005 Opcodes SHALL be:
- 0 NOP.
- 1 LDA: A<=mem[op].
- 2 ADD: B<=mem[op], then A<=A+B.
- 3 SUB: B<=mem[op], then A<=A-B.
- 4 STA: mem[op]<=A.
- 5 LDI: A<=zero-extended op.
- 6 JMP.
- 7 JC.
- 8 JZ.
- 9 JN.
- A to D: NOP.
- E OUTA: OUT<=A.
- F HLT.
REQ-006 Every instruction SHALL take exactly 7 clocks, in microsteps T0 to T6, then return to T0.
REQ-007 Microstep actions SHALL be:
- T0: MAR<=PC.
- T1: IR<=mem[MAR] and PC<=PC+1, wrapping from 0xF to 0x0.
- T2: MAR<=IR[3:0].
- T3: the execute action of REQ-005 (LDA, LDI, STA, OUTA, jump, HLT, and B<=mem[MAR] for ADD/SUB).
- T4: ADD/SUB write A and the flags.
- T5 and T6: idle.
REQ-008 ADD SHALL compute a 9-bit A+B; A takes the low 8 bits and C takes bit 8. Example: FF+01 gives A=00, C=1, Z=1.
REQ-009 SUB SHALL compute A+~B+1; C=1 means no borrow.
REQ-010 Flag updates SHALL be:
- ADD and SUB set Z, N and C from the result.
- LDA and LDI set Z (result==0) and N (bit 7), and clear C.
- All other instructions leave the flags unchanged.
REQ-011 A jump SHALL load PC<=IR[3:0] at T3 when its condition holds (JMP always, JC on C, JZ on Z, JN on N); otherwise the PC keeps the value incremented at T1.
REQ-012 HLT SHALL set an internal signal halt at T3; from then on no register, flag, PC or RAM state changes until reset. The PC therefore stays at HLT address+1.
REQ-013 out_val and the flag outputs SHALL be driven directly from their registers, with no added latency.

Reset
REQ-014 When reset is low at a rising clk edge, the block SHALL clear PC, MAR, IR, A, B, OUT, Z, C, N and halt to 0, and set the microstep to T0.
REQ-015 Reset SHALL take priority over every other action, including in any microstep and while halted.
REQ-016 Reset SHALL NOT alter RAM contents.
REQ-017 The first rising edge with reset high SHALL execute T0.

Configuration
REQ-018 With macro SUB_INSTR_EN defined, opcode 3 SHALL perform SUB as specified.
REQ-019 Without SUB_INSTR_EN, opcode 3 SHALL decode as NOP and no subtractor logic shall be synthesised.

Structure
REQ-020 DATA_WIDTH, ADDR_WIDTH, the opcode enum and the microstep enum SHALL live in the shared package arch_defs_pkg.
REQ-021 A reusable sub-module register_nbit (load enable, synchronous active-low reset, output latched_data) SHALL implement A, B, OUT and IR.
REQ-022 These instance names and signals SHALL be provided:
- u_register_A, u_register_B and u_register_OUT, each exposing latched_data.
- u_program_counter, exposing counter_out.
- u_ram, exposing array mem and a dump task that prints the RAM contents.
- halt at the top level.

Verification
REQ-023 The bench SHALL load this program: 0:LDA F, 1:ADD E, 2:JC 6, 6:LDI 1, 7:JC A, 8:OUTA, 9:HLT, E:01, F:FF.
REQ-024 The bench SHALL cover these scenarios, each stated as stimulus -> required response:
- LDA F -> A=FF, PC=1, Z=0, N=1, C=0.
- ADD E -> B=01, A=00, C=1, Z=1.
- JC 6 with C=1 -> PC=6, A=00.
- LDI 1 -> A=01, Z=0, C=0, PC=7; then JC A with C=0 -> PC=8 (no jump).
- OUTA -> out_val=01, PC=9; HLT -> PC=0A, A=01, OUT=01, halt=1, state frozen for at least 50 further clocks.
- reset low asserted mid-instruction (at T4) -> all registers 0 on the next edge and RAM unchanged; with SUB_INSTR_EN, SUB of 01 from 00 -> A=FF, C=0, N=1.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// Shared definitions for the SAP-2 style computer.
// Contents: default datapath/address widths, RAM depth, opcode enum and
// microstep enum. Imported by sap2_computer and its RAM / PC sub-modules.
// Optional feature macro: SUB_INSTR_EN (enables the SUB instruction, opcode 3).
package arch_defs_pkg;

  localparam int unsigned DATA_WIDTH = 8;
  localparam int unsigned ADDR_WIDTH = 4;
  localparam int unsigned RAM_DEPTH  = 16;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_STA  = 4'h4,
    OP_LDI  = 4'h5,
    OP_JMP  = 4'h6,
    OP_JC   = 4'h7,
    OP_JZ   = 4'h8,
    OP_JN   = 4'h9,
    OP_OUTA = 4'hE,
    OP_HLT  = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5,
    T6 = 3'd6
  } step_e;

endpackage

// File: rtl/register_nbit.sv
// Generic load-enabled register with synchronous active-low reset.
// Used for the A, B, OUT and IR registers.
// Ports:
//   i_clk        clock, rising edge
//   i_rst_n      synchronous active-low reset (clears to 0, wins over load)
//   i_load       load enable
//   i_data       value captured when i_load is high
//   latched_data current register contents
module register_nbit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] latched_data
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      latched_data <= '0;
    end else if (i_load) begin
      latched_data <= i_data;
    end
  end

endmodule

// File: rtl/sap2_computer_pc.sv
// Program counter: increments with natural wrap, or loads a jump target.
// Ports:
//   i_clk       clock, rising edge
//   i_rst_n     synchronous active-low reset (clears to 0)
//   i_inc       increment by one (wraps at the top of the address space)
//   i_load      load i_load_val (takes precedence over i_inc)
//   i_load_val  jump target
//   counter_out current PC value
module sap2_computer_pc #(
  parameter int unsigned ADDR_WIDTH = arch_defs_pkg::ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_inc,
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_load_val,
  output logic [ADDR_WIDTH-1:0] counter_out
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      counter_out <= '0;
    end else if (i_load) begin
      counter_out <= i_load_val;
    end else if (i_inc) begin
      counter_out <= counter_out + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: rtl/sap2_computer_ram.sv
// Unified code/data RAM, asynchronous read, synchronous write.
// Contents are not touched by reset; they are loaded from outside.
// Ports:
//   i_clk   clock, rising edge
//   i_we    write enable
//   i_addr  read/write address
//   i_wdata write data
//   o_rdata combinational read data at i_addr
module sap2_computer_ram #(
  parameter int unsigned DATA_WIDTH = arch_defs_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = arch_defs_pkg::ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = mem[i_addr];

`ifndef SYNTHESIS
  // Simulation-only helper that prints the RAM image.
  task automatic dump();
    for (int unsigned i = 0; i < 2**ADDR_WIDTH; i++) begin
      $display("RAM[%0h] = %h", i, mem[i]);
    end
  endtask
`endif

endmodule

// File: rtl/sap2_computer.sv
// SAP-2 style 8-bit computer: 16-byte unified RAM, A/B/OUT/IR registers,
// Z/C/N flags and a fixed 7-microstep (T0..T6) instruction cycle.
// Optional feature macro: SUB_INSTR_EN -- when defined opcode 3 performs
// A <= A + ~B + 1; otherwise opcode 3 is a NOP and no subtractor exists.
// Ports:
//   clk             system clock, all state on the rising edge
//   reset           synchronous active-low reset (RAM untouched)
//   out_val         OUT register contents
//   flag_zero_o     Z flag
//   flag_carry_o    C flag (for SUB, 1 means no borrow)
//   flag_negative_o N flag
module sap2_computer #(
  parameter int unsigned DATA_WIDTH = arch_defs_pkg::DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = arch_defs_pkg::ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] out_val,
  output logic                  flag_zero_o,
  output logic                  flag_carry_o,
  output logic                  flag_negative_o
);

  import arch_defs_pkg::*;

  step_e                 r_step;
  step_e                 w_step_next;
  logic [ADDR_WIDTH-1:0] r_mar;
  logic                  r_z;
  logic                  r_c;
  logic                  r_n;
  logic                  halt;

  logic [DATA_WIDTH-1:0] w_a;
  logic [DATA_WIDTH-1:0] w_b;
  logic [DATA_WIDTH-1:0] w_out;
  logic [DATA_WIDTH-1:0] w_ir;
  logic [ADDR_WIDTH-1:0] w_pc;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  opcode_e               w_op;
  logic [ADDR_WIDTH-1:0] w_operand;
  logic [DATA_WIDTH:0]   w_sum;
  logic                  w_is_alu;

  logic                  w_mar_load;
  logic [ADDR_WIDTH-1:0] w_mar_d;
  logic                  w_ir_load;
  logic                  w_pc_inc;
  logic                  w_pc_load;
  logic                  w_a_load;
  logic [DATA_WIDTH-1:0] w_a_d;
  logic                  w_b_load;
  logic                  w_out_load;
  logic                  w_ram_we;
  logic                  w_flags_load;
  logic                  w_z_d;
  logic                  w_c_d;
  logic                  w_n_d;
  logic                  w_halt_set;

  assign w_op      = opcode_e'(w_ir[DATA_WIDTH-1 -: 4]);
  assign w_operand = w_ir[ADDR_WIDTH-1:0];

`ifdef SUB_INSTR_EN
  assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB);
  assign w_sum    = (w_op == OP_SUB)
                  ? ({1'b0, w_a} + {1'b0, ~w_b} + (DATA_WIDTH+1)'(1))
                  : ({1'b0, w_a} + {1'b0, w_b});
`else
  assign w_is_alu = (w_op == OP_ADD);
  assign w_sum    = {1'b0, w_a} + {1'b0, w_b};
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_step <= T0;
      r_mar  <= '0;
      r_z    <= 1'b0;
      r_c    <= 1'b0;
      r_n    <= 1'b0;
      halt   <= 1'b0;
    end else begin
      r_step <= w_step_next;
      if (w_mar_load) begin
        r_mar <= w_mar_d;
      end
      if (w_flags_load) begin
        r_z <= w_z_d;
        r_c <= w_c_d;
        r_n <= w_n_d;
      end
      if (w_halt_set) begin
        halt <= 1'b1;
      end
    end
  end

  always_comb begin
    w_step_next  = r_step;
    w_mar_load   = 1'b0;
    w_mar_d      = w_pc;
    w_ir_load    = 1'b0;
    w_pc_inc     = 1'b0;
    w_pc_load    = 1'b0;
    w_a_load     = 1'b0;
    w_a_d        = '0;
    w_b_load     = 1'b0;
    w_out_load   = 1'b0;
    w_ram_we     = 1'b0;
    w_flags_load = 1'b0;
    w_z_d        = r_z;
    w_c_d        = r_c;
    w_n_d        = r_n;
    w_halt_set   = 1'b0;

    // Once halted every enable stays low and the microstep freezes.
    if (!halt) begin
      case (r_step)
        T0: w_step_next = T1;
        T1: w_step_next = T2;
        T2: w_step_next = T3;
        T3: w_step_next = T4;
        T4: w_step_next = T5;
        T5: w_step_next = T6;
        default: w_step_next = T0;
      endcase

      case (r_step)
        T0: begin
          w_mar_load = 1'b1;
          w_mar_d    = w_pc;
        end
        T1: begin
          w_ir_load = 1'b1;
          w_pc_inc  = 1'b1;
        end
        T2: begin
          w_mar_load = 1'b1;
          w_mar_d    = w_operand;
        end
        T3: begin
          case (w_op)
            OP_LDA: begin
              w_a_load     = 1'b1;
              w_a_d        = w_ram_rdata;
              w_flags_load = 1'b1;
            end
            OP_LDI: begin
              w_a_load     = 1'b1;
              w_a_d        = DATA_WIDTH'(w_operand);
              w_flags_load = 1'b1;
            end
            OP_STA:  w_ram_we   = 1'b1;
            OP_OUTA: w_out_load = 1'b1;
            OP_JMP:  w_pc_load  = 1'b1;
            OP_JC:   w_pc_load  = r_c;
            OP_JZ:   w_pc_load  = r_z;
            OP_JN:   w_pc_load  = r_n;
            OP_HLT:  w_halt_set = 1'b1;
            default: w_b_load   = w_is_alu;
          endcase
          if (w_flags_load) begin
            w_z_d = (w_a_d == '0);
            w_n_d = w_a_d[DATA_WIDTH-1];
            w_c_d = 1'b0;
          end
        end
        T4: begin
          if (w_is_alu) begin
            w_a_load     = 1'b1;
            w_a_d        = w_sum[DATA_WIDTH-1:0];
            w_flags_load = 1'b1;
            w_z_d        = (w_sum[DATA_WIDTH-1:0] == '0);
            w_n_d        = w_sum[DATA_WIDTH-1];
            w_c_d        = w_sum[DATA_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  register_nbit #(.WIDTH(DATA_WIDTH)) u_register_A (
    .i_clk(clk), .i_rst_n(reset), .i_load(w_a_load), .i_data(w_a_d),
    .latched_data(w_a)
  );

  register_nbit #(.WIDTH(DATA_WIDTH)) u_register_B (
    .i_clk(clk), .i_rst_n(reset), .i_load(w_b_load), .i_data(w_ram_rdata),
    .latched_data(w_b)
  );

  register_nbit #(.WIDTH(DATA_WIDTH)) u_register_OUT (
    .i_clk(clk), .i_rst_n(reset), .i_load(w_out_load), .i_data(w_a),
    .latched_data(w_out)
  );

  register_nbit #(.WIDTH(DATA_WIDTH)) u_register_IR (
    .i_clk(clk), .i_rst_n(reset), .i_load(w_ir_load), .i_data(w_ram_rdata),
    .latched_data(w_ir)
  );

  sap2_computer_pc #(.ADDR_WIDTH(ADDR_WIDTH)) u_program_counter (
    .i_clk(clk), .i_rst_n(reset), .i_inc(w_pc_inc), .i_load(w_pc_load),
    .i_load_val(w_operand), .counter_out(w_pc)
  );

  sap2_computer_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .i_clk(clk), .i_we(w_ram_we), .i_addr(r_mar), .i_wdata(w_a),
    .o_rdata(w_ram_rdata)
  );

  assign out_val         = w_out;
  assign flag_zero_o     = r_z;
  assign flag_carry_o    = r_c;
  assign flag_negative_o = r_n;

endmodule

// File: tb/tb_sap2_computer.sv
// Directed testbench for sap2_computer: runs the reference program
// instruction by instruction against a table of hand-computed states,
// then exercises reset while halted, reset mid-instruction and opcode 3.
module tb_sap2_computer;

  logic       clk;
  logic       reset;
  logic [7:0] out_val;
  logic       flag_zero_o;
  logic       flag_carry_o;
  logic       flag_negative_o;

  int unsigned n_tests;
  int unsigned n_fail;

  sap2_computer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk),
    .reset(reset),
    .out_val(out_val),
    .flag_zero_o(flag_zero_o),
    .flag_carry_o(flag_carry_o),
    .flag_negative_o(flag_negative_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int unsigned clocks;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  pc;
    logic [7:0]  out;
    logic        z;
    logic        c;
    logic        n;
    logic        h;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] prog[16];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input vec_t v);
    chk($sformatf("%s.A", v.name),   16'(dut.u_register_A.latched_data), 16'(v.a));
    chk($sformatf("%s.B", v.name),   16'(dut.u_register_B.latched_data), 16'(v.b));
    chk($sformatf("%s.PC", v.name),  16'(dut.u_program_counter.counter_out), 16'(v.pc));
    chk($sformatf("%s.OUT", v.name), 16'(out_val), 16'(v.out));
    chk($sformatf("%s.Z", v.name),   16'(flag_zero_o), 16'(v.z));
    chk($sformatf("%s.C", v.name),   16'(flag_carry_o), 16'(v.c));
    chk($sformatf("%s.N", v.name),   16'(flag_negative_o), 16'(v.n));
    chk($sformatf("%s.HALT", v.name), 16'(dut.halt), 16'(v.h));
  endtask

  task automatic run(input int unsigned clocks);
    repeat (clocks) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    vec_t zero_v;
    n_tests = 0;
    n_fail  = 0;

    //          name     clk  A      B      PC    OUT    Z     C     N     H
    vecs[0] = '{"LDA_F",  7, 8'hFF, 8'h00, 4'h1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{"ADD_E",  7, 8'h00, 8'h01, 4'h2, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"JC_6",   7, 8'h00, 8'h01, 4'h6, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"LDI_1",  7, 8'h01, 8'h01, 4'h7, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"JC_A",   7, 8'h01, 8'h01, 4'h8, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"OUTA",   7, 8'h01, 8'h01, 4'h9, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{"HLT",    7, 8'h01, 8'h01, 4'hA, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{"FROZEN", 50, 8'h01, 8'h01, 4'hA, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
    zero_v  = '{"RESET",  0, 8'h00, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    prog[0]  = 8'h1F; // LDA F
    prog[1]  = 8'h2E; // ADD E
    prog[2]  = 8'h76; // JC 6
    prog[6]  = 8'h51; // LDI 1
    prog[7]  = 8'h7A; // JC A
    prog[8]  = 8'hE0; // OUTA
    prog[9]  = 8'hF0; // HLT
    prog[14] = 8'h01;
    prog[15] = 8'hFF;
    for (int i = 0; i < 16; i++) dut.u_ram.mem[i] = prog[i];

    reset = 1'b0;
    run(2);
    chk_state(zero_v);
    chk("RESET.IR", 16'(dut.u_register_IR.latched_data), 16'h0000);

    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run(vecs[i].clocks);
      chk_state(vecs[i]);
    end

    // Reset while halted clears everything including halt.
    reset = 1'b0;
    run(1);
    zero_v.name = "RST_HALTED";
    chk_state(zero_v);

    // Reset at T4 of LDA F: A holds FF after T3, must clear on that edge.
    reset = 1'b1;
    run(4);
    chk("PRE_RST_T4.A", 16'(dut.u_register_A.latched_data), 16'h00FF);
    reset = 1'b0;
    run(1);
    zero_v.name = "RST_T4";
    chk_state(zero_v);
    chk("RST_T4.IR", 16'(dut.u_register_IR.latched_data), 16'h0000);
    for (int i = 0; i < 16; i++)
      chk($sformatf("RAM[%0d]", i), 16'(dut.u_ram.mem[i]), 16'(prog[i]));
    dut.u_ram.dump();

    // First edge after release executes T0: LDA F completes after 7 clocks.
    reset = 1'b1;
    run(7);
    vecs[0].name = "RELDA_F";
    chk_state(vecs[0]);

    // Opcode 3: LDI 0 then SUB E (E holds 01).
    reset = 1'b0;
    dut.u_ram.mem[0] = 8'h50;
    dut.u_ram.mem[1] = 8'h3E;
    run(1);
    reset = 1'b1;
    run(14);
`ifdef SUB_INSTR_EN
    chk_state('{"SUB", 0, 8'hFF, 8'h01, 4'h2, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0});
`else
    chk_state('{"OP3_NOP", 0, 8'h00, 8'h00, 4'h2, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
